// File: rtl/gpu_layer_ram_pkg.sv
// Shared types and default widths for the layer RAM arbiter and its base table.
package gpu_layer_ram_pkg;

  localparam int ADDR_W       = 24;
  localparam int DATA_W       = 16;
  localparam int LID_W        = 8;
  localparam int NUM_LAYERS   = 8;
  localparam int STARVE_LIMIT = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE_RD,
    ST_WAIT_RD,
    ST_ISSUE_WR,
    ST_WAIT_WR
  } state_e;

  typedef enum logic {
    OWN_PIPE,
    OWN_CTRL
  } owner_e;

endpackage

// File: rtl/layer_base_table.sv
// Per-layer SDRAM base address registers: one synchronous write port and two
// combinational read ports. Ids beyond the table read as 0 and never write.
module layer_base_table #(
  parameter int ADDR_W     = gpu_layer_ram_pkg::ADDR_W,
  parameter int LID_W      = gpu_layer_ram_pkg::LID_W,
  parameter int NUM_LAYERS = gpu_layer_ram_pkg::NUM_LAYERS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we_i,
  input  logic [LID_W-1:0]  cfg_layer_id_i,
  input  logic [ADDR_W-1:0] cfg_base_i,
  input  logic [LID_W-1:0]  pipe_id_i,
  input  logic [LID_W-1:0]  ctrl_id_i,
  output logic [ADDR_W-1:0] pipe_base_o,
  output logic [ADDR_W-1:0] ctrl_base_o
);

  logic [NUM_LAYERS-1:0][ADDR_W-1:0] base_q;

  generate
    for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst) begin
          base_q[gi] <= '0;
        end else if (cfg_we_i && (cfg_layer_id_i == LID_W'(gi))) begin
          base_q[gi] <= cfg_base_i;
        end
      end
    end
  endgenerate

  // Full-width compare against each entry index keeps out-of-range ids from aliasing.
  always_comb begin
    pipe_base_o = '0;
    ctrl_base_o = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (pipe_id_i == LID_W'(i)) pipe_base_o = base_q[i];
      if (ctrl_id_i == LID_W'(i)) ctrl_base_o = base_q[i];
    end
  end

endmodule

// File: rtl/layer_ram_arbiter.sv
// Shares the single SDRAM host port between pipeline reads and controller
// reads/writes, one command in flight, with starvation protection for ctrl.
module layer_ram_arbiter #(
  parameter int ADDR_W       = gpu_layer_ram_pkg::ADDR_W,
  parameter int DATA_W       = gpu_layer_ram_pkg::DATA_W,
  parameter int NUM_LAYERS   = gpu_layer_ram_pkg::NUM_LAYERS,
  parameter int LID_W        = gpu_layer_ram_pkg::LID_W,
  parameter int STARVE_LIMIT = gpu_layer_ram_pkg::STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [LID_W-1:0]  cfg_layer_id,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic              pipe_req,
  input  logic [LID_W-1:0]  pipe_layer_id,
  input  logic [ADDR_W-1:0] pipe_addr_bytes,
  output logic              pipe_gnt,
  output logic              pipe_rvalid,
  input  logic              ctrl_req,
  input  logic              ctrl_we,
  input  logic [LID_W-1:0]  ctrl_layer_id,
  input  logic              ctrl_restart,
  input  logic [DATA_W-1:0] ctrl_wdata,
  output logic              ctrl_gnt,
  output logic              ctrl_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] sd_addr,
  output logic [DATA_W-1:0] sd_wdata,
  output logic              sd_wr_en,
  output logic              sd_rd_en,
  input  logic [DATA_W-1:0] sd_rdata,
  input  logic              sd_rd_ready,
  input  logic              sd_busy,
  output logic              idle
);

  import gpu_layer_ram_pkg::*;

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  state_e            state_q, state_d;
  owner_e            owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              pipe_rvalid_q, ctrl_rvalid_q;
  logic [SW-1:0]     starve_q, starve_d;
  logic [ADDR_W-1:0] offset_q;
  logic [LID_W-1:0]  last_id_q;

  logic [ADDR_W-1:0] pipe_base, ctrl_base;
  logic [ADDR_W-1:0] eff_off, pipe_addr, ctrl_addr;

  layer_base_table #(
    .ADDR_W     (ADDR_W),
    .LID_W      (LID_W),
    .NUM_LAYERS (NUM_LAYERS)
  ) u_base_table (
    .clk            (clk),
    .rst            (rst),
    .cfg_we_i       (cfg_we),
    .cfg_layer_id_i (cfg_layer_id),
    .cfg_base_i     (cfg_base),
    .pipe_id_i      (pipe_layer_id),
    .ctrl_id_i      (ctrl_layer_id),
    .pipe_base_o    (pipe_base),
    .ctrl_base_o    (ctrl_base)
  );

  // Auto-increment only continues while ctrl keeps addressing the same layer.
  assign eff_off   = (ctrl_restart || (ctrl_layer_id != last_id_q)) ? '0 : offset_q;
  assign ctrl_addr = ctrl_base + eff_off;
  assign pipe_addr = pipe_base + (pipe_addr_bytes >> 1);

  always_comb begin
    state_d  = state_q;
    pipe_gnt = 1'b0;
    ctrl_gnt = 1'b0;
    sd_rd_en = 1'b0;
    sd_wr_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!sd_busy && !rst) begin
          if (ctrl_req && (!pipe_req || (starve_q == SW'(STARVE_LIMIT)))) begin
            ctrl_gnt = 1'b1;
            state_d  = ctrl_we ? ST_ISSUE_WR : ST_ISSUE_RD;
          end else if (pipe_req) begin
            pipe_gnt = 1'b1;
            state_d  = ST_ISSUE_RD;
          end
        end
      end
      ST_ISSUE_RD: begin
        sd_rd_en = 1'b1;
        state_d  = ST_WAIT_RD;
      end
      ST_WAIT_RD: begin
        if (sd_rd_ready) state_d = ST_IDLE;
      end
      ST_ISSUE_WR: begin
        sd_wr_en = 1'b1;
        state_d  = ST_WAIT_WR;
      end
      ST_WAIT_WR: begin
        if (!sd_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (ctrl_gnt || !ctrl_req) begin
      starve_d = '0;
    end else if (pipe_gnt && (starve_q != SW'(STARVE_LIMIT))) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      owner_q       <= OWN_PIPE;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      pipe_rvalid_q <= 1'b0;
      ctrl_rvalid_q <= 1'b0;
      starve_q      <= '0;
      offset_q      <= '0;
      last_id_q     <= '0;
    end else begin
      state_q       <= state_d;
      starve_q      <= starve_d;
      pipe_rvalid_q <= 1'b0;
      ctrl_rvalid_q <= 1'b0;
      if (ctrl_gnt) begin
        addr_q    <= ctrl_addr;
        wdata_q   <= ctrl_wdata;
        owner_q   <= OWN_CTRL;
        offset_q  <= eff_off + ADDR_W'(1);
        last_id_q <= ctrl_layer_id;
      end else if (pipe_gnt) begin
        addr_q  <= pipe_addr;
        owner_q <= OWN_PIPE;
      end
      if ((state_q == ST_WAIT_RD) && sd_rd_ready) begin
        rdata_q       <= sd_rdata;
        pipe_rvalid_q <= (owner_q == OWN_PIPE);
        ctrl_rvalid_q <= (owner_q == OWN_CTRL);
      end
    end
  end

  assign sd_addr     = addr_q;
  assign sd_wdata    = wdata_q;
  assign rdata       = rdata_q;
  assign pipe_rvalid = pipe_rvalid_q;
  assign ctrl_rvalid = ctrl_rvalid_q;
  assign idle        = (state_q == ST_IDLE);

endmodule

// File: tb/tb_layer_ram_arbiter.sv
// Randomised and directed checks of layer_ram_arbiter against a small
// behavioural model of the base table, ctrl offset and starvation rule.
module tb_layer_ram_arbiter;

  localparam int AW = 24;
  localparam int DW = 16;
  localparam int LW = 8;
  localparam int NL = 8;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_we = 1'b0;
  logic [LW-1:0] cfg_layer_id = '0;
  logic [AW-1:0] cfg_base = '0;
  logic          pipe_req = 1'b0;
  logic [LW-1:0] pipe_layer_id = '0;
  logic [AW-1:0] pipe_addr_bytes = '0;
  logic          pipe_gnt, pipe_rvalid;
  logic          ctrl_req = 1'b0;
  logic          ctrl_we = 1'b0;
  logic [LW-1:0] ctrl_layer_id = '0;
  logic          ctrl_restart = 1'b0;
  logic [DW-1:0] ctrl_wdata = '0;
  logic          ctrl_gnt, ctrl_rvalid;
  logic [DW-1:0] rdata;
  logic [AW-1:0] sd_addr;
  logic [DW-1:0] sd_wdata;
  logic          sd_wr_en, sd_rd_en;
  logic [DW-1:0] sd_rdata = '0;
  logic          sd_rd_ready;
  logic          sd_busy = 1'b0;
  logic          idle;

  logic man_ready = 1'b0;
  logic auto_resp = 1'b0;
  logic auto_pend = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Minimal SDRAM responder: answers a read strobe one cycle later.
  always @(posedge clk) auto_pend <= auto_resp & sd_rd_en;
  assign sd_rd_ready = man_ready | auto_pend;

  layer_ram_arbiter dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_layer_id(cfg_layer_id), .cfg_base(cfg_base),
    .pipe_req(pipe_req), .pipe_layer_id(pipe_layer_id), .pipe_addr_bytes(pipe_addr_bytes),
    .pipe_gnt(pipe_gnt), .pipe_rvalid(pipe_rvalid),
    .ctrl_req(ctrl_req), .ctrl_we(ctrl_we), .ctrl_layer_id(ctrl_layer_id),
    .ctrl_restart(ctrl_restart), .ctrl_wdata(ctrl_wdata),
    .ctrl_gnt(ctrl_gnt), .ctrl_rvalid(ctrl_rvalid), .rdata(rdata),
    .sd_addr(sd_addr), .sd_wdata(sd_wdata), .sd_wr_en(sd_wr_en), .sd_rd_en(sd_rd_en),
    .sd_rdata(sd_rdata), .sd_rd_ready(sd_rd_ready), .sd_busy(sd_busy), .idle(idle)
  );

  // ---------------- reference model ----------------
  int            base_m [NL];
  int            off_m;
  int            last_m;
  logic [DW-1:0] rdata_m;

  task automatic model_reset();
    for (int i = 0; i < NL; i++) base_m[i] = 0;
    off_m   = 0;
    last_m  = 0;
    rdata_m = '0;
  endtask

  function automatic int base_of(input int id);
    return (id < NL) ? base_m[id] : 0;
  endfunction

  function automatic int exp_pipe(input int id, input int bytes);
    return (base_of(id) + bytes / 2) % (1 << AW);
  endfunction

  task automatic model_ctrl(input int id, input bit restart, output int addr);
    int eff;
    eff    = (restart || id != last_m) ? 0 : off_m;
    addr   = (base_of(id) + eff) % (1 << AW);
    off_m  = (eff + 1) % (1 << AW);
    last_m = id;
  endtask

  // ---------------- stimulus helpers ----------------
  typedef struct {
    bit            timeout;
    bit            both_gnt;
    logic          rd_en;
    logic          wr_en;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          en_after;
    logic          rv_p;
    logic          rv_c;
    logic [DW-1:0] rdata;
    logic          idle_d;
    logic          rv_after;
  } obs_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int id, input int base);
    tick();
    cfg_we       = 1'b1;
    cfg_layer_id = LW'(id);
    cfg_base     = AW'(base);
    tick();
    cfg_we = 1'b0;
    if (id < NL) base_m[id] = base;
  endtask

  // Runs one full transaction and reports what the DUT did; no judging here.
  task automatic txn(input bit is_ctrl, input bit we, input bit restart, input int id,
                     input int bytes, input logic [DW-1:0] wd, input logic [DW-1:0] rv,
                     output obs_t o);
    bit got;
    o = '{default: 0};
    tick();
    if (is_ctrl) begin
      ctrl_req = 1'b1; ctrl_we = we; ctrl_restart = restart;
      ctrl_layer_id = LW'(id); ctrl_wdata = wd;
    end else begin
      pipe_req = 1'b1; pipe_layer_id = LW'(id); pipe_addr_bytes = AW'(bytes);
    end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (pipe_gnt && ctrl_gnt) o.both_gnt = 1'b1;
      if (is_ctrl ? ctrl_gnt : pipe_gnt) got = 1'b1;
      else tick();
    end
    if (!got) begin
      o.timeout = 1'b1;
      tick();
      pipe_req = 1'b0; ctrl_req = 1'b0;
      return;
    end
    tick();
    pipe_req = 1'b0; ctrl_req = 1'b0; ctrl_restart = 1'b0; ctrl_we = 1'b0;
    @(negedge clk);
    o.rd_en = sd_rd_en; o.wr_en = sd_wr_en; o.addr = sd_addr; o.wdata = sd_wdata;
    tick();
    if (!(is_ctrl && we)) begin
      man_ready = 1'b1;
      sd_rdata  = rv;
    end
    @(negedge clk);
    o.en_after = sd_rd_en | sd_wr_en;
    tick();
    man_ready = 1'b0;
    @(negedge clk);
    o.rv_p = pipe_rvalid; o.rv_c = ctrl_rvalid; o.rdata = rdata; o.idle_d = idle;
    tick();
    @(negedge clk);
    o.rv_after = pipe_rvalid | ctrl_rvalid;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    n_checks++;
    if (idle !== 1'b1) begin
      n_fail++; $display("FAIL reset_idle: got %b expected 1", idle);
    end
    n_checks++;
    if ({pipe_gnt, ctrl_gnt, pipe_rvalid, ctrl_rvalid, sd_wr_en, sd_rd_en} !== 6'b0 ||
        sd_addr !== '0 || sd_wdata !== '0 || rdata !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got gnt=%b%b rv=%b%b en=%b%b addr=%h wd=%h rd=%h expected all 0",
               pipe_gnt, ctrl_gnt, pipe_rvalid, ctrl_rvalid, sd_wr_en, sd_rd_en, sd_addr, sd_wdata, rdata);
    end
    $display("test_reset done");
  endtask

  task automatic test_pipe_read();
    obs_t o;
    cfg_write(2, 'h001000);
    txn(1'b0, 1'b0, 1'b0, 2, 'h10, '0, 16'hBEEF, o);
    n_checks++;
    if (o.timeout || o.addr !== 24'h001008 || o.rd_en !== 1'b1 || o.wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL pipe_issue: got to=%0b addr=%h rd=%b wr=%b expected addr=001008 rd=1 wr=0",
               o.timeout, o.addr, o.rd_en, o.wr_en);
    end
    n_checks++;
    if (o.en_after !== 1'b0) begin
      n_fail++; $display("FAIL pipe_rd_en_width: got enable in 2nd cycle %b expected 0", o.en_after);
    end
    n_checks++;
    if (o.rv_p !== 1'b1 || o.rv_c !== 1'b0 || o.rdata !== 16'hBEEF || o.rv_after !== 1'b0) begin
      n_fail++;
      $display("FAIL pipe_rvalid: got rvp=%b rvc=%b rdata=%h after=%b expected 1 0 BEEF 0",
               o.rv_p, o.rv_c, o.rdata, o.rv_after);
    end
    rdata_m = 16'hBEEF;
    $display("test_pipe_read: addr=%h rdata=%h", o.addr, o.rdata);
  endtask

  task automatic test_ctrl_writes();
    obs_t o;
    int   ea;
    int   ids [5]  = '{1, 1, 1, 1, 3};
    bit   rsts [5] = '{0, 0, 0, 1, 0};
    int   want [5] = '{'h200, 'h201, 'h202, 'h200, 'h000};
    cfg_write(1, 'h000200);
    for (int k = 0; k < 5; k++) begin
      logic [DW-1:0] wd;
      wd = DW'('hA1 + k);
      model_ctrl(ids[k], rsts[k], ea);
      txn(1'b1, 1'b1, rsts[k], ids[k], 0, wd, '0, o);
      n_checks++;
      if (o.timeout || o.addr !== AW'(want[k]) || o.wr_en !== 1'b1 || o.rd_en !== 1'b0 ||
          o.wdata !== wd || o.en_after !== 1'b0) begin
        n_fail++;
        $display("FAIL ctrl_write[%0d]: got to=%0b addr=%h wr=%b rd=%b wd=%h en2=%b expected addr=%h wr=1 rd=0 wd=%h en2=0",
                 k, o.timeout, o.addr, o.wr_en, o.rd_en, o.wdata, o.en_after, want[k], wd);
      end
      n_checks++;
      if (o.rv_p !== 1'b0 || o.rv_c !== 1'b0 || o.idle_d !== 1'b1) begin
        n_fail++;
        $display("FAIL ctrl_write_done[%0d]: got rvp=%b rvc=%b idle=%b expected 0 0 1", k, o.rv_p, o.rv_c, o.idle_d);
      end
      $display("test_ctrl_writes: k=%0d addr=%h wdata=%h", k, o.addr, o.wdata);
    end
  endtask

  task automatic test_wrap_and_range();
    obs_t o;
    cfg_write(0, 'hFFFFFF);
    txn(1'b0, 1'b0, 1'b0, 0, 'h4, '0, 16'h1111, o);
    n_checks++;
    if (o.timeout || o.addr !== 24'h000001) begin
      n_fail++; $display("FAIL addr_wrap: got %h expected 000001", o.addr);
    end
    cfg_write(9, 'h123456);
    txn(1'b0, 1'b0, 1'b0, 9, 'h0, '0, 16'h2222, o);
    n_checks++;
    if (o.timeout || o.addr !== 24'h000000) begin
      n_fail++; $display("FAIL out_of_range_read: got %h expected 000000", o.addr);
    end
    txn(1'b0, 1'b0, 1'b0, 1, 'h0, '0, 16'h3333, o);
    n_checks++;
    if (o.timeout || o.addr !== AW'(exp_pipe(1, 0))) begin
      n_fail++; $display("FAIL out_of_range_alias: got %h expected %h", o.addr, exp_pipe(1, 0));
    end
    rdata_m = 16'h3333;
    $display("test_wrap_and_range: last addr=%h", o.addr);
  endtask

  task automatic test_starvation();
    logic [9:0] got_v, exp_v;
    int         ngr, consec, ea;
    bit         both;
    got_v = '0; exp_v = '0; ngr = 0; consec = 0; both = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (consec == SL) begin
        exp_v[k] = 1'b1; consec = 0;
        model_ctrl(5, 1'b0, ea);
      end else begin
        consec++;
      end
    end
    sd_rdata  = 16'h5A5A;
    auto_resp = 1'b1;
    tick();
    pipe_req = 1'b1; pipe_layer_id = 8'd0; pipe_addr_bytes = '0;
    ctrl_req = 1'b1; ctrl_we = 1'b0; ctrl_layer_id = 8'd5; ctrl_restart = 1'b0;
    for (int c = 0; c < 200 && ngr < 10; c++) begin
      @(negedge clk);
      if (pipe_gnt && ctrl_gnt) both = 1'b1;
      if (ctrl_gnt) begin got_v[ngr] = 1'b1; ngr++; end
      else if (pipe_gnt) begin ngr++; end
      tick();
    end
    pipe_req = 1'b0; ctrl_req = 1'b0;
    repeat (6) tick();
    auto_resp = 1'b0;
    rdata_m   = 16'h5A5A;
    n_checks++;
    if (ngr != 10 || got_v !== exp_v) begin
      n_fail++;
      $display("FAIL starve_order: got %0d grants order(bit=ctrl,lsb first)=%b expected 10 grants %b", ngr, got_v, exp_v);
    end
    n_checks++;
    if (both) begin
      n_fail++; $display("FAIL starve_one_gnt: got two grants in one cycle, expected at most one");
    end
    $display("test_starvation: order=%b", got_v);
  endtask

  task automatic test_busy_hold();
    int bad;
    bit seen_p, seen_c;
    bad = 0;
    auto_resp = 1'b1;
    tick();
    sd_busy  = 1'b1;
    pipe_req = 1'b1; pipe_layer_id = 8'd2; pipe_addr_bytes = '0;
    ctrl_req = 1'b1; ctrl_we = 1'b0; ctrl_layer_id = 8'd5;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_checks++;
      if (pipe_gnt || ctrl_gnt || sd_rd_en || sd_wr_en) begin
        n_fail++;
        $display("FAIL busy_hold[%0d]: got gnt=%b%b en=%b%b expected 0000", c, pipe_gnt, ctrl_gnt, sd_rd_en, sd_wr_en);
      end
      tick();
    end
    sd_busy = 1'b0;
    @(negedge clk);
    seen_p = pipe_gnt; seen_c = ctrl_gnt;
    tick();
    pipe_req = 1'b0; ctrl_req = 1'b0;
    repeat (6) tick();
    auto_resp = 1'b0;
    rdata_m   = sd_rdata;
    n_checks++;
    if (seen_p !== 1'b1 || seen_c !== 1'b0) begin
      n_fail++; $display("FAIL busy_release: got pipe_gnt=%b ctrl_gnt=%b expected 1 0", seen_p, seen_c);
    end
    $display("test_busy_hold: release grant pipe=%b ctrl=%b", seen_p, seen_c);
  endtask

  task automatic test_random();
    obs_t o;
    for (int k = 0; k < 30; k++) begin
      int            kind, id, bytes, ea;
      bit            rs;
      logic [DW-1:0] wd, rv;
      if ($urandom_range(0, 2) == 0) cfg_write($urandom_range(0, 10), $urandom_range(0, 'hFFFFFF));
      kind  = $urandom_range(0, 2);
      bytes = $urandom_range(0, 'hFFFFFF);
      wd    = DW'($urandom);
      rv    = DW'($urandom);
      rs    = ($urandom_range(0, 4) == 0);
      if (kind == 0) begin
        id = $urandom_range(0, 10);
        ea = exp_pipe(id, bytes);
        txn(1'b0, 1'b0, 1'b0, id, bytes, wd, rv, o);
      end else begin
        id = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 10) : last_m;
        model_ctrl(id, rs, ea);
        txn(1'b1, kind == 2, rs, id, bytes, wd, rv, o);
      end
      if (kind != 2) rdata_m = rv;
      n_checks++;
      if (o.timeout || o.both_gnt || o.addr !== AW'(ea) || o.rd_en !== (kind != 2) ||
          o.wr_en !== (kind == 2) || o.en_after !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_issue[%0d]: kind=%0d id=%0d got to=%0b addr=%h rd=%b wr=%b en2=%b expected addr=%h",
                 k, kind, id, o.timeout, o.addr, o.rd_en, o.wr_en, o.en_after, ea);
      end
      n_checks++;
      if ((kind == 2 && o.wdata !== wd) || o.rv_p !== (kind == 0) || o.rv_c !== (kind == 1) ||
          o.rdata !== rdata_m || o.rv_after !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_result[%0d]: kind=%0d got wd=%h rvp=%b rvc=%b rdata=%h after=%b expected wd=%h rdata=%h",
                 k, kind, o.wdata, o.rv_p, o.rv_c, o.rdata, o.rv_after, wd, rdata_m);
      end
      $display("test_random: k=%0d kind=%0d id=%0d addr=%h", k, kind, id, o.addr);
    end
  endtask

  task automatic test_reset_mid_read();
    obs_t o;
    bit   got;
    got = 1'b0;
    tick();
    pipe_req = 1'b1; pipe_layer_id = 8'd2; pipe_addr_bytes = '0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (pipe_gnt) got = 1'b1; else tick();
    end
    tick();
    pipe_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; man_ready = 1'b1; sd_rdata = 16'h1234;
    model_reset();
    @(negedge clk);
    n_checks++;
    if (!got || idle !== 1'b1 || pipe_rvalid !== 1'b0 || ctrl_rvalid !== 1'b0 || sd_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_read: got gnt_seen=%0b idle=%b rv=%b%b rd_en=%b expected 1 1 00 0",
               got, idle, pipe_rvalid, ctrl_rvalid, sd_rd_en);
    end
    tick();
    man_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (pipe_rvalid !== 1'b0 || ctrl_rvalid !== 1'b0 || rdata !== '0) begin
      n_fail++;
      $display("FAIL rst_stale_ready: got rv=%b%b rdata=%h expected 00 0000", pipe_rvalid, ctrl_rvalid, rdata);
    end
    txn(1'b0, 1'b0, 1'b0, 2, 'h20, '0, 16'h7777, o);
    n_checks++;
    if (o.timeout || o.addr !== AW'(exp_pipe(2, 'h20)) || o.rv_p !== 1'b1 || o.rdata !== 16'h7777) begin
      n_fail++;
      $display("FAIL rst_recover: got to=%0b addr=%h rvp=%b rdata=%h expected addr=%h rvp=1 rdata=7777",
               o.timeout, o.addr, o.rv_p, o.rdata, exp_pipe(2, 'h20));
    end
    $display("test_reset_mid_read: recovery addr=%h", o.addr);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_pipe_read();
    test_ctrl_writes();
    test_wrap_and_range();
    test_starvation();
    test_busy_hold();
    test_random();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/layer_ram_arbiter.md
Name: layer_ram_arbiter

Overview:
- Arbitrates and sequences the single SDRAM host port (sdram_controller wr/rd interface) between the render pipeline read requester and the GPU controller read/write requester.
- Owns the per-layer SDRAM base-address table and the controller auto-increment offset.
- Sits between the pipeline layer fetch stage and sdram_controller, one command in flight at a time.

Parameters:
- ADDR_W, 24, SDRAM word address width.
- DATA_W, 16, SDRAM data width.
- NUM_LAYERS, 8, entries in the base table.
- LID_W, 8, layer id port width.
- STARVE_LIMIT, 4, consecutive pipeline grants allowed while ctrl_req is pending.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- cfg_we  in  1  write base table entry.
- cfg_layer_id  in  LID_W  entry index.
- cfg_base  in  ADDR_W  base word address.
- pipe_req  in  1  pipeline read request; held with fields until pipe_gnt.
- pipe_layer_id  in  LID_W  layer of request.
- pipe_addr_bytes  in  ADDR_W  byte offset within layer.
- pipe_gnt  out  1  request accepted (combinational).
- pipe_rvalid  out  1  rdata valid for pipeline.
- ctrl_req  in  1  controller request; held until ctrl_gnt.
- ctrl_we  in  1  1 = write, 0 = read.
- ctrl_layer_id  in  LID_W  layer of request.
- ctrl_restart  in  1  clear auto-increment offset.
- ctrl_wdata  in  DATA_W  write data.
- ctrl_gnt  out  1  request accepted (combinational).
- ctrl_rvalid  out  1  rdata valid for controller.
- rdata  out  DATA_W  registered read data.
- sd_addr  out  ADDR_W  drives both wr_addr and rd_addr.
- sd_wdata  out  DATA_W  drives wr_data.
- sd_wr_en  out  1  drives wr_enable.
- sd_rd_en  out  1  drives rd_enable.
- sd_rdata  in  DATA_W  from rd_data.
- sd_rd_ready  in  1  from rd_ready.
- sd_busy  in  1  from busy.
- idle  out  1  FSM in IDLE.

Behaviour:
Reset:
- All outputs 0, except idle = 1.
- Base table entries = 0.
- Offset = 0, last_ctrl_id = 0, starve_cnt = 0.
- Reset mid-operation: next cycle is IDLE with enables low. Any in-flight read result is discarded (no rvalid). sdram_controller is not reset by this block.

FSM states: IDLE, ISSUE_RD, WAIT_RD, ISSUE_WR, WAIT_WR.
- IDLE: arbitrates only when sd_busy = 0.
  - Winner rule: ctrl wins if ctrl_req and (!pipe_req or starve_cnt == STARVE_LIMIT); otherwise pipe wins if pipe_req.
  - The winner's gnt is high for that one cycle. Address, wdata, owner and read/write are latched.
  - Next state: ISSUE_WR if ctrl and ctrl_we, else ISSUE_RD.
- ISSUE_RD / ISSUE_WR: exactly one cycle with sd_rd_en / sd_wr_en = 1 and sd_addr / sd_wdata from the latches. Then go to WAIT_RD / WAIT_WR.
- WAIT_RD: on sd_rd_ready, capture sd_rdata into rdata and return to IDLE. The owner's rvalid pulses for one cycle, coincident with that IDLE cycle. rdata holds until the next capture.
- WAIT_WR: minimum 1 cycle. Exit to IDLE on the first cycle with sd_busy = 0. No completion pulse.
- sd_rd_ready outside WAIT_RD is ignored.

Starvation counter:
- Increments on a pipe grant while ctrl_req = 1, saturating at STARVE_LIMIT.
- Clears on a ctrl grant, or on any cycle with ctrl_req = 0.

Address arithmetic (ADDR_W bits, wraps modulo 2^ADDR_W, no error):
- pipe: base[pipe_layer_id] + (pipe_addr_bytes >> 1).
- ctrl: base[ctrl_layer_id] + eff_off.
  - eff_off = 0 if ctrl_restart or ctrl_layer_id != last_ctrl_id; otherwise offset.
  - On a ctrl grant: offset <= eff_off + 1, last_ctrl_id <= ctrl_layer_id.

Base table:
- cfg_we writes take effect the following cycle. A same-cycle grant uses the old value.
- layer_id >= NUM_LAYERS reads base 0; cfg writes to such ids are ignored.
- cfg writes are accepted in every state.

Simultaneous events:
- pipe_req and ctrl_req in the same cycle: resolved by the winner rule above.
- At most one gnt is high per cycle.

Decomposition:
- Package gpu_layer_ram_pkg holds: the state enum, ADDR_W/DATA_W/LID_W constants, and the owner typedef (OWN_PIPE, OWN_CTRL).
- Sub-module layer_base_table: NUM_LAYERS x ADDR_W register file with synchronous write and combinational read ports (pipe id, ctrl id), including the out-of-range handling.

Test Plan:
- Reset, then cfg base[2] = 0x001000; pipe read layer 2, bytes 0x000010 -> sd_addr = 0x001008, sd_rd_en one cycle. sd_rd_ready with sd_rdata = 0xBEEF -> rdata = 0xBEEF, pipe_rvalid one pulse, ctrl_rvalid = 0.
- Three ctrl writes to layer 1 (base 0x000200), wdata 0xA1/0xA2/0xA3 -> sd_addr 0x200/0x201/0x202. Then ctrl_restart -> 0x200. Switch to layer 3 (base 0) -> 0x000.
- pipe_req and ctrl_req held continuously, STARVE_LIMIT = 4 -> grant order P,P,P,P,C,P,P,P,P,C; never two gnts in one cycle.
- sd_busy held high 10 cycles in IDLE with both requests pending -> no gnt, no enables. After busy falls, the grant follows on that cycle.
- base[0] = 0xFFFFFF, pipe bytes 0x000004 -> sd_addr = 0x000001 (wrap). cfg to layer 9 is ignored; a read of layer 9 uses base 0.
- rst asserted while in WAIT_RD, then sd_rd_ready arrives -> no rvalid, idle = 1 the cycle after rst; the next request proceeds normally.
